// File: rtl/rx_frame_parser.sv
// rx_frame_parser
// Receive-side command frame parser. Consumes bytes from the UART receiver and
// validates 5-byte request frames (ID_H, ID_L, CMD, CRC_LO, CRC_HI) against the
// node address and a CRC-16/MODBUS over ID_H, ID_L and CMD. Each accepted frame
// updates cmd and pulses cmd_flag; a CRC mismatch or an inter-byte timeout
// pulses frame_err.
//
// Parameters:
//   DEV_ID       device address this node answers to
//   TIMEOUT_CYC  idle cycles between bytes inside a frame that abort it
// Ports:
//   sys_clk       in   1  system clock, rising edge
//   sys_rst       in   1  asynchronous active-high reset
//   rx_byte       in   8  received byte, valid while rx_byte_flag is high
//   rx_byte_flag  in   1  one-cycle strobe per received byte
//   cmd           out  8  last accepted command byte (held between frames)
//   cmd_flag      out  1  one-cycle pulse when cmd is updated
//   frame_err     out  1  one-cycle pulse on CRC mismatch or timeout
module rx_frame_parser #(
  parameter logic [15:0] DEV_ID      = 16'h0000,
  parameter int          TIMEOUT_CYC = 100000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_flag,
  output logic [7:0] cmd,
  output logic       cmd_flag,
  output logic       frame_err
);

  localparam int          CW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {S_IDH, S_IDL, S_CMD, S_CRCL, S_CRCH} state_t;

  state_t        state_reg, state_next;
  logic [15:0]   crc_reg, crc_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    cmd_hold_reg, cmd_hold_next;
  logic          lo_match_reg, lo_match_next;
  logic [7:0]    cmd_next;
  logic          cmd_flag_next, frame_err_next;
  logic [15:0]   crc_step;
  logic          timeout;

  // One full byte of CRC-16/MODBUS (reflected 0xA001), 8 shift steps unrolled.
  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ 16'hA001;
      else      c = c >> 1;
    end
    return c;
  endfunction

  assign crc_step = crc_byte(crc_reg, rx_byte);
  assign timeout  = (state_reg != S_IDH) && (cnt_reg == T_LAST);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg    <= S_IDH;
      crc_reg      <= CRC_INIT;
      cnt_reg      <= '0;
      cmd_hold_reg <= 8'h00;
      lo_match_reg <= 1'b0;
      cmd          <= 8'h00;
      cmd_flag     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      crc_reg      <= crc_next;
      cnt_reg      <= cnt_next;
      cmd_hold_reg <= cmd_hold_next;
      lo_match_reg <= lo_match_next;
      cmd          <= cmd_next;
      cmd_flag     <= cmd_flag_next;
      frame_err    <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    crc_next       = crc_reg;
    cnt_next       = cnt_reg;
    cmd_hold_next  = cmd_hold_reg;
    lo_match_next  = lo_match_reg;
    cmd_next       = cmd;
    cmd_flag_next  = 1'b0;
    frame_err_next = 1'b0;

    if (rx_byte_flag) begin
      // A strobe always wins over a coincident timeout.
      cnt_next = '0;
      case (state_reg)
        S_IDH: begin
          crc_next = CRC_INIT;
          if (rx_byte == DEV_ID[15:8]) begin
            crc_next   = crc_step;
            state_next = S_IDL;
          end
        end
        S_IDL: begin
          if (rx_byte == DEV_ID[7:0]) begin
            crc_next   = crc_step;
            state_next = S_CMD;
          end else begin
            crc_next   = CRC_INIT;
            state_next = S_IDH;
          end
        end
        S_CMD: begin
          cmd_hold_next = rx_byte;
          crc_next      = crc_step;
          state_next    = S_CRCL;
        end
        S_CRCL: begin
          lo_match_next = (rx_byte == crc_reg[7:0]);
          state_next    = S_CRCH;
        end
        S_CRCH: begin
          if (lo_match_reg && (rx_byte == crc_reg[15:8])) begin
            cmd_next      = cmd_hold_reg;
            cmd_flag_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
          crc_next   = CRC_INIT;
          state_next = S_IDH;
        end
        default: begin
          crc_next   = CRC_INIT;
          state_next = S_IDH;
        end
      endcase
    end else if (timeout) begin
      frame_err_next = 1'b1;
      crc_next       = CRC_INIT;
      cnt_next       = '0;
      state_next     = S_IDH;
    end else if (state_reg == S_IDH) begin
      crc_next = CRC_INIT;
      cnt_next = '0;
    end else if (cnt_reg != T_LAST) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Testbench for rx_frame_parser. Stimulus pushes expected pulses (kind, cmd
// value, negedge index at which the pulse must be visible) into a queue; a
// monitor on the falling edge pops and compares whenever cmd_flag or
// frame_err is high.
module tb_rx_frame_parser;

  localparam int TO = 16;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_byte_flag = 1'b0;
  logic [7:0] cmd;
  logic       cmd_flag;
  logic       frame_err;

  rx_frame_parser #(.DEV_ID(16'h0000), .TIMEOUT_CYC(TO)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .rx_byte      (rx_byte),
    .rx_byte_flag (rx_byte_flag),
    .cmd          (cmd),
    .cmd_flag     (cmd_flag),
    .frame_err    (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit       is_err;
    logic [7:0] cmd;
    int       at;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   neg_cyc = 0;

  // Monitor: neg_cyc counts falling edges; pulses are compared in order.
  always @(negedge sys_clk) begin
    neg_cyc++;
    if (!sys_rst && (cmd_flag || frame_err)) begin
      exp_t e;
      checks++;
      if (cmd_flag && frame_err) begin
        errors++;
        $display("FAIL both_pulses: cmd_flag=%0b frame_err=%0b, required not both high", cmd_flag, frame_err);
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cmd_flag=%0b frame_err=%0b cmd=%02h at cyc %0d, required no pulse",
                 cmd_flag, frame_err, cmd, neg_cyc);
      end else begin
        e = exp_q.pop_front();
        if (frame_err != e.is_err) begin
          errors++;
          $display("FAIL pulse_kind: frame_err=%0b cmd_flag=%0b, required frame_err=%0b", frame_err, cmd_flag, e.is_err);
        end
        checks++;
        if (neg_cyc != e.at) begin
          errors++;
          $display("FAIL pulse_time: got cyc %0d, required cyc %0d", neg_cyc, e.at);
        end
        if (!e.is_err) begin
          checks++;
          if (cmd != e.cmd) begin
            errors++;
            $display("FAIL cmd_value: got %02h, required %02h", cmd, e.cmd);
          end
        end
        $display("pulse %s cmd=%02h at cyc %0d (expected cyc %0d)", frame_err ? "err" : "cmd", cmd, neg_cyc, e.at);
      end
    end
  end

  // Called #1 after a rising edge; the byte is sampled on the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_byte      = b;
    rx_byte_flag = 1'b1;
    @(posedge sys_clk);
    #1;
    rx_byte_flag = 1'b0;
  endtask

  // Called right after the sampling edge of the byte that causes the pulse.
  task automatic expect_pulse(input bit is_err, input logic [7:0] c, input int delay);
    exp_t e;
    e.is_err = is_err;
    e.cmd    = c;
    e.at     = neg_cyc + 1 + delay;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4, input bit ok, input logic [7:0] c);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    send_byte(b4);
    expect_pulse(!ok, c, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check_cmd(input string name, input logic [7:0] want);
    checks++;
    if (cmd !== want) begin
      errors++;
      $display("FAIL %s: cmd=%02h, required %02h", name, cmd, want);
    end else
      $display("check %s cmd=%02h", name, cmd);
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (cmd !== 8'h00 || cmd_flag !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: cmd=%02h cmd_flag=%0b frame_err=%0b, required 00/0/0", cmd, cmd_flag, frame_err);
    end else
      $display("check reset_state ok");
    sys_rst = 1'b0;
    idle(2);

    // Valid frame.
    send_frame(8'h00, 8'h00, 8'h01, 8'hB0, 8'h00, 1'b1, 8'h01);
    idle(3);
    check_cmd("valid_frame", 8'h01);

    // Back-to-back frames, consecutive strobes: pulses 5 cycles apart.
    send_frame(8'h00, 8'h00, 8'h01, 8'hB0, 8'h00, 1'b1, 8'h01);
    send_frame(8'h00, 8'h00, 8'h02, 8'hF0, 8'h01, 1'b1, 8'h02);
    idle(3);
    check_cmd("back_to_back", 8'h02);

    // Bad CRC high byte.
    send_frame(8'h00, 8'h00, 8'h02, 8'hF0, 8'h00, 1'b0, 8'h00);
    idle(3);
    check_cmd("bad_crc_hold", 8'h02);

    // Wrong ID: no pulses. The trailing 00 is taken as a fresh ID_H, so an FF
    // is sent to return the parser to S_IDH before its timeout could fire.
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'hB0);
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(TO + 8);
    check_cmd("wrong_id_hold", 8'h02);

    // Timeout: 16 idle cycles after ID_L abort the frame.
    send_byte(8'h00);
    send_byte(8'h00);
    expect_pulse(1'b1, 8'h00, TO);
    idle(TO + 4);

    // Timeout recovery.
    send_frame(8'h00, 8'h00, 8'h02, 8'hF0, 8'h01, 1'b1, 8'h02);
    idle(3);
    check_cmd("timeout_recovery", 8'h02);

    // Reset mid-frame: partial frame dropped, cmd returns to 00.
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    sys_rst = 1'b1;
    idle(3);
    sys_rst = 1'b0;
    check_cmd("reset_mid_frame", 8'h00);
    send_byte(8'hB0);
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(TO + 8);
    check_cmd("reset_no_pulse", 8'h00);

    // Reset recovery.
    send_frame(8'h00, 8'h00, 8'h01, 8'hB0, 8'h00, 1'b1, 8'h01);
    idle(3);
    check_cmd("reset_recovery", 8'h01);

    idle(TO + 4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: %0d outstanding, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
